// File: rtl/debug_pkg.sv
// Shared definitions for the debug dump transmitter: FSM state encoding
// and frame constants.
package debug_pkg;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        SEND_HDR   = 4'd1,
        SEND_PC_H  = 4'd2,
        SEND_PC_L  = 4'd3,
        SEND_ACC_H = 4'd4,
        SEND_ACC_L = 4'd5,
        MEM_REQ    = 4'd6,
        MEM_WAIT   = 4'd7,
        SEND_MEM_H = 4'd8,
        SEND_MEM_L = 4'd9,
        DONE       = 4'd10
    } state_t;

    // First byte of every frame.
    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Header + PC (2 bytes) + ACC (2 bytes); memory words follow.
    localparam int FRAME_FIXED_BYTES = 5;

    // Total bytes in a frame dumping n_words memory words.
    function automatic int frame_len(input int n_words);
        return FRAME_FIXED_BYTES + 2 * n_words;
    endfunction

endpackage

// File: rtl/debug_dump_tx_byte_issuer.sv
// Hands one byte at a time to uart_tx: a load pulse latches the byte and
// raises a single-cycle tx_start; the matching tx_done comes back as "sent".
module byte_issuer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_byte,
    input  logic       tx_done,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       sent
);

    logic pending_q;

    // A done that lands on the start cycle belongs to an earlier byte, so it
    // is masked; only a done while the byte is outstanding counts.
    assign sent = pending_q & tx_done & ~tx_start;

    // Latch the byte, pulse tx_start once, track the outstanding byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data   <= 8'h00;
            tx_start  <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            tx_start <= load;
            if (load) begin
                tx_data   <= load_byte;
                pending_q <= 1'b1;
            end else if (sent) begin
                pending_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/debug_dump_tx.sv
// Debug dump transmitter: on start, snapshots PC/ACC and streams
// HEADER, PC, ACC and N_WORDS data-memory words to uart_tx, MSB byte first.
module debug_dump_tx
    import debug_pkg::*;
#(
    parameter int         DATA_WIDTH = 16,
    parameter int         ADDR_WIDTH = 11,
    parameter int         N_WORDS    = 16,
    parameter logic [7:0] HEADER     = HEADER_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH-1:0] i_PC,
    input  logic [DATA_WIDTH-1:0] i_ACC,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic                  o_mem_rd,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_done
);

    // One extra bit so N_WORDS = 2^ADDR_WIDTH is representable.
    localparam int CNT_W = ADDR_WIDTH + 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [7:0]            word_lo_q;
    logic [CNT_W-1:0]      cnt_q;

    logic [15:0] pc16, acc16, mem16;
    logic        snap, cnt_inc, word_ld, load, sent, last_word;
    logic [7:0]  load_byte;

    // Frame fields are 16 bits wide; PC is zero-extended.
    assign pc16      = 16'(pc_q);
    assign acc16     = 16'(acc_q);
    assign mem16     = 16'(i_mem_data);
    assign last_word = (cnt_q == CNT_W'(N_WORDS - 1));

    assign o_mem_addr = cnt_q[ADDR_WIDTH-1:0];
    assign o_busy     = (state_q != IDLE) && (state_q != DONE);
    assign o_done     = (state_q == DONE);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Snapshot, word counter and low half of the fetched memory word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_q      <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            word_lo_q <= 8'h00;
        end else begin
            if (snap) begin
                pc_q  <= i_PC;
                acc_q <= i_ACC;
                cnt_q <= '0;
            end else if (cnt_inc) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (word_ld) word_lo_q <= mem16[7:0];
        end
    end

    // Next state; each SEND_* byte is loaded on the transition into it so
    // tx_start rises on that state's first cycle. The high memory byte comes
    // straight from the read port because it is only registered at that edge.
    always_comb begin
        state_d   = state_q;
        snap      = 1'b0;
        cnt_inc   = 1'b0;
        word_ld   = 1'b0;
        load      = 1'b0;
        load_byte = 8'h00;
        o_mem_rd  = 1'b0;
        unique case (state_q)
            IDLE: if (i_start) begin
                snap = 1'b1; load = 1'b1; load_byte = HEADER; state_d = SEND_HDR;
            end
            SEND_HDR: if (sent) begin
                load = 1'b1; load_byte = pc16[15:8]; state_d = SEND_PC_H;
            end
            SEND_PC_H: if (sent) begin
                load = 1'b1; load_byte = pc16[7:0]; state_d = SEND_PC_L;
            end
            SEND_PC_L: if (sent) begin
                load = 1'b1; load_byte = acc16[15:8]; state_d = SEND_ACC_H;
            end
            SEND_ACC_H: if (sent) begin
                load = 1'b1; load_byte = acc16[7:0]; state_d = SEND_ACC_L;
            end
            SEND_ACC_L: if (sent) state_d = MEM_REQ;
            MEM_REQ: begin
                o_mem_rd = 1'b1; state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                word_ld = 1'b1; load = 1'b1; load_byte = mem16[15:8]; state_d = SEND_MEM_H;
            end
            SEND_MEM_H: if (sent) begin
                load = 1'b1; load_byte = word_lo_q; state_d = SEND_MEM_L;
            end
            SEND_MEM_L: if (sent) begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    cnt_inc = 1'b1; state_d = MEM_REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    byte_issuer u_issuer (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .load      (load),
        .load_byte (load_byte),
        .tx_done   (i_tx_done),
        .tx_data   (o_tx_data),
        .tx_start  (o_tx_start),
        .sent      (sent)
    );

endmodule

// File: tb/tb_debug_dump_tx.sv
// Randomized self-checking bench for debug_dump_tx with a behavioural
// uart_tx / data-memory environment and a byte-list frame model.
module tb_debug_dump_tx;

    localparam int NW = 2;

    logic        clk = 1'b0;
    logic        i_rst_n, i_start, i_tx_done, o_mem_rd, o_tx_start, o_busy, o_done;
    logic [10:0] i_PC, o_mem_addr;
    logic [15:0] i_ACC, i_mem_data;
    logic [7:0]  o_tx_data;

    logic        model_done, spur_done;
    int          lat;
    logic [15:0] mem [0:NW-1];

    logic [7:0]  got_bytes[$];
    logic [10:0] rd_addrs[$];
    logic [7:0]  exp_q[$];
    int          done_cnt = 0, overlap = 0, rd_multi = 0;
    int          n_checks = 0, n_errors = 0;

    assign i_tx_done = model_done | spur_done;

    always #5 clk = ~clk;

    debug_dump_tx #(
        .DATA_WIDTH (16),
        .ADDR_WIDTH (11),
        .N_WORDS    (NW),
        .HEADER     (8'hA5)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (i_rst_n),
        .i_start    (i_start),
        .i_PC       (i_PC),
        .i_ACC      (i_ACC),
        .o_mem_addr (o_mem_addr),
        .o_mem_rd   (o_mem_rd),
        .i_mem_data (i_mem_data),
        .o_tx_data  (o_tx_data),
        .o_tx_start (o_tx_start),
        .i_tx_done  (i_tx_done),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    // Frame model: header, PC and ACC big-endian, then every memory word.
    task automatic model_frame(input logic [10:0] pc, input logic [15:0] acc);
        logic [15:0] pc16;
        pc16 = {5'b0, pc};
        exp_q.push_back(8'hA5);
        exp_q.push_back(pc16[15:8]);
        exp_q.push_back(pc16[7:0]);
        exp_q.push_back(acc[15:8]);
        exp_q.push_back(acc[7:0]);
        for (int a = 0; a < NW; a++) begin
            exp_q.push_back(mem[a][15:8]);
            exp_q.push_back(mem[a][7:0]);
        end
    endtask

    task automatic compare_bytes(input int base);
        check("frame_len", got_bytes.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (base + i < got_bytes.size())
                check($sformatf("byte%0d", i), got_bytes[base+i], exp_q[i]);
        exp_q.delete();
    endtask

    task automatic check_reads(input int r0, input int frames);
        check("rd_count", rd_addrs.size() - r0, frames * NW);
        for (int i = 0; i < frames * NW; i++)
            if (r0 + i < rd_addrs.size())
                check($sformatf("rd_addr%0d", i), rd_addrs[r0+i], i % NW);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!o_done && n < budget) begin
            cyc();
            n++;
        end
        check("done_seen", o_done, 1);
    endtask

    task automatic pulse_start(input logic [10:0] pc, input logic [15:0] acc);
        cyc();
        i_PC = pc; i_ACC = acc; i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        i_ACC = 16'h0000;
        i_PC = 11'($urandom);
    endtask

    task automatic run_frame(input logic [10:0] pc, input logic [15:0] acc, input bit spur_start);
        int base, d0, r0;
        base = got_bytes.size(); d0 = done_cnt; r0 = rd_addrs.size();
        model_frame(pc, acc);
        pulse_start(pc, acc);
        check("busy_after_start", o_busy, 1);
        if (spur_start) begin
            repeat (25) cyc();
            i_start = 1'b1; i_PC = 11'($urandom); i_ACC = 16'($urandom);
            cyc();
            i_start = 1'b0;
        end
        wait_done(3000);
        cyc();
        check("busy_after_done", o_busy, 0);
        check("done_pulses", done_cnt - d0, 1);
        compare_bytes(base);
        check_reads(r0, 1);
    endtask

    // Output monitor.
    initial begin
        logic prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (o_tx_start) got_bytes.push_back(o_tx_data);
            if (o_mem_rd) rd_addrs.push_back(o_mem_addr);
            if (o_mem_rd && o_tx_start) overlap++;
            if (o_mem_rd && prev_rd) rd_multi++;
            prev_rd = o_mem_rd;
            if (o_done) done_cnt++;
        end
    end

    // uart_tx model: done pulse lat cycles after each start.
    initial begin
        int cd = 0;
        model_done = 1'b0;
        forever begin
            @(negedge clk);
            model_done = 1'b0;
            if (!i_rst_n) cd = 0;
            else if (o_tx_start) cd = lat;
            else if (cd > 0) begin
                cd--;
                if (cd == 0) model_done = 1'b1;
            end
        end
    end

    // Data memory: valid data only in the cycle after a read strobe.
    initial begin
        logic        rd_seen;
        logic [10:0] ra;
        i_mem_data = 16'h0000;
        forever begin
            @(negedge clk);
            rd_seen = o_mem_rd;
            ra = o_mem_addr;
            @(posedge clk);
            #1;
            i_mem_data = (rd_seen && ra < NW) ? mem[ra] : 16'($urandom);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, d0, r0;
        logic [10:0] pc1, pc2;
        logic [15:0] acc1, acc2;
        i_rst_n = 1'b0; i_start = 1'b0; i_PC = '0; i_ACC = '0; spur_done = 1'b0; lat = 10;
        #3;
        check("rst_tx_start", o_tx_start, 0);
        check("rst_tx_data", o_tx_data, 0);
        check("rst_mem_rd", o_mem_rd, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_busy", o_busy, 0);
        check("rst_done", o_done, 0);
        repeat (3) @(negedge clk);
        #1 i_rst_n = 1'b1;

        // Basic frame with ACC changed right after the snapshot.
        mem[0] = 16'h001F; mem[1] = 16'hBEEF;
        run_frame(11'h123, 16'hF800, 1'b0);

        // Spurious tx_done in IDLE, then a frame with a mid-frame start.
        base = got_bytes.size();
        repeat (3) begin
            cyc(); spur_done = 1'b1;
            cyc(); spur_done = 1'b0;
        end
        cyc();
        check("idle_busy", o_busy, 0);
        check("idle_no_bytes", got_bytes.size() - base, 0);
        run_frame(11'h123, 16'hF800, 1'b1);

        // Random frames with random uart latency.
        for (int k = 0; k < 6; k++) begin
            lat = $urandom_range(1, 12);
            mem[0] = 16'($urandom); mem[1] = 16'($urandom);
            run_frame(11'($urandom), 16'($urandom), 1'b0);
        end

        // Reset while the ACC high byte is outstanding.
        lat = 10;
        base = got_bytes.size();
        pulse_start(11'h7FF, 16'h1234);
        begin
            int n = 0;
            while (got_bytes.size() < base + 4 && n < 200) begin
                cyc();
                n++;
            end
        end
        check("abort_reached_acc_h", got_bytes.size() - base, 4);
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_tx_start", o_tx_start, 0);
        check("arst_tx_data", o_tx_data, 0);
        check("arst_busy", o_busy, 0);
        check("arst_mem_addr", o_mem_addr, 0);
        repeat (2) cyc();
        i_rst_n = 1'b1;
        mem[0] = 16'hC3A5; mem[1] = 16'h0102;
        run_frame(11'h0AB, 16'h8001, 1'b0);

        // Back-to-back frames with one-cycle done latency.
        lat = 1;
        pc1 = 11'($urandom); acc1 = 16'($urandom);
        pc2 = 11'($urandom); acc2 = 16'($urandom);
        base = got_bytes.size(); d0 = done_cnt; r0 = rd_addrs.size();
        model_frame(pc1, acc1);
        model_frame(pc2, acc2);
        pulse_start(pc1, acc1);
        wait_done(1000);
        cyc();
        i_PC = pc2; i_ACC = acc2; i_start = 1'b1;
        cyc();
        i_start = 1'b0; i_ACC = 16'h0000;
        wait_done(1000);
        cyc();
        check("b2b_done_pulses", done_cnt - d0, 2);
        compare_bytes(base);
        check_reads(r0, 2);
        check("b2b_busy_end", o_busy, 0);

        check("rd_tx_overlap", overlap, 0);
        check("rd_single_cycle", rd_multi, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
